// File: rtl/demux_12_reg_pkg.sv
// Shared constants and helpers for the registered 1-to-2 demultiplexer.
package demux_12_reg_pkg;

  // Destination port encodings (matches the 1-bit sel / rr_ptr value).
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Steering modes.
  localparam int RR_OFF = 0;  // destination taken from sel
  localparam int RR_ON  = 1;  // destination alternates, sel ignored

  // A one-entry slot can take a new word when it is empty or being emptied
  // in the same cycle.
  function automatic logic slot_free(input logic valid, input logic ready);
    return (!valid) | ready;
  endfunction

endpackage

// File: rtl/demux_12_reg_if.sv
// Bus bundle of the demultiplexer: one valid/ready input stream, two
// valid/ready output ports and the per-port transfer counters.
interface demux_12_reg_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              sel;

  logic [DATA_W-1:0] out0_data;
  logic              out0_valid;
  logic              out0_ready;

  logic [DATA_W-1:0] out1_data;
  logic              out1_valid;
  logic              out1_ready;

  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;

  // Producer / consumer side (drives the input stream and the output readys).
  modport master (
    output in_data, in_valid, sel, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );

  // Demultiplexer side.
  modport slave (
    input  in_data, in_valid, sel, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux_out_slot.sv
// One-entry output holding register with valid flag and a wrapping
// count of the words loaded into it.
module demux_out_slot
  import demux_12_reg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,   // accepted word steered to this slot
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,  // consumer takes the held word
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_free    // slot can take a word this cycle
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  // Holding register: a load wins over a drain, so a same-cycle drain and
  // refill keeps the slot full with the new word.
  // NOTE: state is updated with <= so every flop samples pre-edge values;
  // the data register is reset too because its value is a visible output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      if (i_load) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
        r_cnt   <= r_cnt + CNT_W'(1);
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;
  assign o_free  = slot_free(r_valid, i_ready);

endmodule

// File: rtl/demux_12_reg.sv
// Registered 1-to-2 demultiplexer: steers each accepted input word to one
// of two one-entry output slots, chosen by sel or by a round-robin pointer.
module demux_12_reg
  import demux_12_reg_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8,
  parameter int RR_MODE = RR_OFF
) (
  input  logic           clk,
  input  logic           rst,
  demux_12_reg_if.slave  bus
);

  logic r_rr_ptr;
  logic w_dst;
  logic w_free0;
  logic w_free1;
  logic w_accept;
  logic w_load0;
  logic w_load1;

  // Destination select: live sel (not latched) or the round-robin pointer.
  // NOTE: combinational blocks assign a default first so no latch is inferred.
  always_comb begin
    w_dst = bus.sel;
    if (RR_MODE == RR_ON) begin
      w_dst = r_rr_ptr;
    end
  end

  // in_ready follows the selected slot only; the path from outD_ready is
  // combinational on purpose to allow one word per cycle per port.
  assign bus.in_ready = (w_dst == PORT1) ? w_free1 : w_free0;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_load0      = w_accept & (w_dst == PORT0);
  assign w_load1      = w_accept & (w_dst == PORT1);

  // Round-robin pointer: flips only on an accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= PORT0;
    end else if ((RR_MODE == RR_ON) && w_accept) begin
      r_rr_ptr <= ~r_rr_ptr;
    end
  end

  demux_out_slot #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_slot0 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load0),
    .i_data  (bus.in_data),
    .i_ready (bus.out0_ready),
    .o_valid (bus.out0_valid),
    .o_data  (bus.out0_data),
    .o_cnt   (bus.cnt0),
    .o_free  (w_free0)
  );

  demux_out_slot #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_slot1 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load1),
    .i_data  (bus.in_data),
    .i_ready (bus.out1_ready),
    .o_valid (bus.out1_valid),
    .o_data  (bus.out1_data),
    .o_cnt   (bus.cnt1),
    .o_free  (w_free1)
  );

endmodule

// File: doc/demux_12_reg.md
Name: demux_12_reg

Overview:
- Registered 1-to-2 demultiplexer: the distribution end of the 2:1 selection path.
- Takes one valid/ready input stream and steers each accepted word to one of two output ports.
- Each output port has a one-entry holding register.
- Used to fan ALU results or operands out to two consumers, for example a register write port and a display/debug port.

Parameters:
- DATA_W, 8, data word width in bits.
- CNT_W, 8, width of the per-port transfer counters.
- RR_MODE, 0: 0 means destination taken from sel; 1 means round-robin alternation with sel ignored.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  input word.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts in_data this cycle.
- sel  in  1  destination select (0 = out0, 1 = out1); used only when RR_MODE=0.
- out0_data  out  DATA_W  held word for port 0.
- out0_valid  out  1  port 0 buffer full.
- out0_ready  in  1  port 0 consumer takes the word.
- out1_data  out  DATA_W  held word for port 1.
- out1_valid  out  1  port 1 buffer full.
- out1_ready  in  1  port 1 consumer takes the word.
- cnt0  out  CNT_W  words accepted for port 0.
- cnt1  out  CNT_W  words accepted for port 1.

Behaviour:
- Reset, asynchronous and effective immediately:
  - out0_valid and out1_valid = 0.
  - out0_data and out1_data = 0.
  - cnt0 and cnt1 = 0.
  - rr_ptr = 0.
- Reset mid-operation discards buffered words and no handshake completes in that cycle.
- Destination dst, combinational each cycle: dst = sel when RR_MODE=0, dst = rr_ptr when RR_MODE=1.
- in_ready = (!outD_valid) | outD_ready, where D = dst.
  - This is a combinational path from outD_ready to in_ready and is intended.
  - in_ready does not depend on in_valid.
- Accept occurs when in_valid & in_ready. On the next edge:
  - outD_data <= in_data.
  - outD_valid <= 1.
  - cntD <= cntD + 1, wrapping modulo 2^CNT_W (all-ones + 1 = 0).
  - In RR_MODE, rr_ptr <= ~rr_ptr.
- Drain occurs when outN_valid & outN_ready. On the next edge, outN_valid <= 0, unless the same port is refilled in that cycle.
- Simultaneous drain and refill of the same port: outN_valid stays 1 and outN_data takes the new word.
  - This gives full throughput of 1 word/cycle per port while the consumer keeps ready high.
- Latency: a word accepted in cycle N is visible at outD_data/outD_valid in cycle N+1.
- outN_data is stable while outN_valid=1 and outN_ready=0.
- Stall: if the selected port is full and not draining, in_ready=0.
  - No counter or pointer changes.
  - The other port continues to drain independently.
- sel may change while stalled; the destination follows the current sel (no latching before accept).
- rr_ptr advances only on accept, never on stall or drain.
- outN_valid and outN_data are driven directly from registers, with no combinational path from in_* to out*_.
- Out-of-range values cannot occur, since sel is 1 bit.

Decomposition:
- Shared package/header holds:
  - PORT0 = 1'b0 and PORT1 = 1'b1 constants.
  - RR_OFF = 0 and RR_ON = 1 mode constants.
- One natural sub-module, demux_out_slot:
  - A one-entry holding register with valid flag, load enable, ready input and transfer counter.
  - Instantiated twice.
  - Top level holds dst/rr_ptr logic and the in_ready mux.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle while both buffers are full with cnt0=3 -> out*_valid=0, cnt0=cnt1=0, rr_ptr=0 immediately, before the next edge.
2. Steering, RR_MODE=0, both readys=1:
   - Stimulus: send 0xA5 with sel=0, then 0x3C with sel=1 on consecutive cycles.
   - Required: out0 shows 0xA5 one cycle after its accept, out1 shows 0x3C one cycle after its accept, cnt0=1, cnt1=1.
3. Backpressure:
   - Stimulus: out0_ready=0; send 0x11 then 0x22, both with sel=0.
   - Required: 0x11 is held on out0 and in_ready=0 for the second word.
   - Then raise out0_ready for one cycle: 0x11 is consumed, 0x22 is loaded in the same cycle, out0_valid stays 1, cnt0=2.
4. Independent port:
   - Stimulus: port 0 full and stalled; send 0x77 with sel=1.
   - Required: in_ready=1, out1 gets 0x77, out0 stays unchanged.
5. Round-robin, RR_MODE=1:
   - Stimulus: send 0x01..0x04 with sel held at 1.
   - Required: out0 receives 0x01 and 0x03, out1 receives 0x02 and 0x04.
   - Stall for 3 cycles with no pointer advance, then the next word goes to out0.
6. Counter wrap, CNT_W=8: perform 256 accepts to port 1 -> cnt1 goes 255 -> 0 and cnt0 stays 0.
